// File: rtl/rr_arbiter8.sv
// Eight-way request arbiter with round-robin or fixed MSB-first priority,
// bounded hold time with forced revocation, and registered outputs.
module rr_arbiter8 #(
  parameter int RR       = 1,
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state_q;
  logic [7:0] grant_q;
  logic [2:0] grant_id_q;
  logic       grant_valid_q;
  logic       timeout_q;
  logic [7:0] hold_cnt_q;
  logic [2:0] last_id_q;
  logic [2:0] win_id_d;
  logic       release_d;
  logic       expire_d;

  // Highest set index wins; ascending scan lets later hits overwrite.
  function automatic logic [2:0] pick_fixed(input logic [7:0] r);
    logic [2:0] id;
    id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r[i]) id = 3'(i);
    end
    return id;
  endfunction

  // Downward search starting just below the previous winner, wrapping 0 -> 7.
  function automatic logic [2:0] pick_rr(input logic [7:0] r, input logic [2:0] last);
    logic [2:0] id;
    logic [2:0] idx;
    logic       found;
    id    = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last - 3'(k);
      if (!found && r[idx]) begin
        id    = idx;
        found = 1'b1;
      end
    end
    return id;
  endfunction

  always_comb begin
    win_id_d  = (RR != 0) ? pick_rr(req, last_id_q) : pick_fixed(req);
    release_d = done || !req[grant_id_q];
    expire_d  = (hold_cnt_q == 8'(HOLD_MAX - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= 8'd0;
      grant_id_q    <= 3'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      hold_cnt_q    <= 8'd0;
      last_id_q     <= 3'd0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q       <= HOLD;
            grant_q       <= 8'd1 << win_id_d;
            grant_id_q    <= win_id_d;
            grant_valid_q <= 1'b1;
            last_id_q     <= win_id_d;
            hold_cnt_q    <= 8'd0;
          end
        end
        HOLD: begin
          // A voluntary release on the expiry cycle suppresses the timeout pulse.
          if (release_d) begin
            state_q       <= IDLE;
            grant_q       <= 8'd0;
            grant_valid_q <= 1'b0;
          end else if (expire_d) begin
            state_q       <= IDLE;
            grant_q       <= 8'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule
